// File: rtl/riscv_ctrl_pkg.sv
// Shared definitions for the multicycle RV32I control unit: FSM state type,
// datapath mux select codes, ALU operation codes and the opcodes the
// controller understands.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    MEMADR,
    MEMREAD,
    MEMWB,
    MEMWRITE,
    EXECR,
    EXECI,
    ALUWB,
    BEQ,
    JAL,
    ILLEGAL
  } statetype;

  // ALUControl codes
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  // ALUOp: what the main FSM asks of the ALU decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // ResultSrc
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  // ALUSrcA
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_A     = 2'b10;

  // ALUSrcB
  localparam logic [1:0] SRCB_B    = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // ImmSrc
  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  // Opcodes
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

endpackage

// File: rtl/aludec.sv
// ALU decoder: maps the FSM's ALUOp plus the instruction's funct3/funct7b5
// fields onto an ALUControl code.
//   alu_op      in  2  00 add, 01 sub, 10 decode from funct3
//   funct3      in  3  Instr[14:12]
//   funct7b5    in  1  Instr[30]
//   op5         in  1  Instr[5] (distinguishes R-type from I-type)
//   alu_control out 3  ALU operation
//   unsupported out 1  funct3 is outside the implemented set
module aludec
  import riscv_ctrl_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       op5,
  output logic [2:0] alu_control,
  output logic       unsupported
);

  logic [2:0] funct_control;

  // The unsupported flag depends on funct3 alone so the FSM can consult it
  // in DECODE, before it has switched ALUOp over to funct3 decoding.
  always_comb begin
    funct_control = ALU_ADD;
    unsupported   = 1'b0;
    case (funct3)
      // Only R-type encodes sub via funct7b5; addi's imm[10] must stay add.
      3'b000:  funct_control = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
      3'b010:  funct_control = ALU_SLT;
      3'b100:  funct_control = ALU_XOR;
      3'b110:  funct_control = ALU_OR;
      3'b111:  funct_control = ALU_AND;
      default: begin
        funct_control = ALU_ADD;
        unsupported   = 1'b1;
      end
    endcase
  end

  always_comb begin
    case (alu_op)
      ALUOP_ADD:   alu_control = ALU_ADD;
      ALUOP_SUB:   alu_control = ALU_SUB;
      ALUOP_FUNCT: alu_control = funct_control;
      default:     alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Control unit for the multicycle RV32I datapath. A Moore main FSM steps
// each instruction through 3-5 cycles; the ALU decoder and immediate-type
// decoder complete the block. Unsupported encodings park the FSM in a
// sticky ILLEGAL state until reset.
//   clk        in   1  rising-edge clock
//   reset      in   1  asynchronous active-low reset
//   op         in   7  Instr[6:0]
//   funct3     in   3  Instr[14:12]
//   funct7b5   in   1  Instr[30]
//   Zero       in   1  ALU zero flag
//   PCWrite    out  1  PC enable
//   AdrSrc     out  1  memory address select (0 PC, 1 ALUOut)
//   MemWrite   out  1  memory write enable
//   IRWrite    out  1  IR/OldPC enable
//   ResultSrc  out  2  result mux select
//   ALUSrcA    out  2  ALU A-operand select
//   ALUSrcB    out  2  ALU B-operand select
//   RegWrite   out  1  register file write enable
//   ImmSrc     out  2  immediate format
//   ALUControl out  3  ALU operation
//   illegal    out  1  high while parked in ILLEGAL
module multicycle_controller
  import riscv_ctrl_pkg::*;
#(
  parameter statetype RESET_STATE = FETCH
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       RegWrite,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic       illegal
);

  statetype   state, next_state;
  logic [1:0] alu_op;
  logic       branch;
  logic       pc_update;
  logic       unsupported;
  logic       decode_bad;

  // All outputs are Moore decodes of state, so clearing state asynchronously
  // forces the FETCH output set immediately with no write-enable glitch.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= RESET_STATE;
    else        state <= next_state;
  end

  assign decode_bad = (((op == OP_R) || (op == OP_I)) && unsupported) ||
                      ((op == OP_BRANCH) && (funct3 != 3'b000));

  always_comb begin
    next_state = state;
    IRWrite    = 1'b0;
    AdrSrc     = 1'b0;
    MemWrite   = 1'b0;
    RegWrite   = 1'b0;
    ResultSrc  = RES_ALUOUT;
    ALUSrcA    = SRCA_PC;
    ALUSrcB    = SRCB_B;
    alu_op     = ALUOP_ADD;
    branch     = 1'b0;
    pc_update  = 1'b0;
    illegal    = 1'b0;
    case (state)
      FETCH: begin
        IRWrite    = 1'b1;
        ALUSrcB    = SRCB_FOUR;
        ResultSrc  = RES_ALURESULT;
        pc_update  = 1'b1;
        next_state = DECODE;
      end
      DECODE: begin
        // Branch target is computed here into ALUOut for a later BEQ.
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        if (decode_bad) begin
          next_state = ILLEGAL;
        end else begin
          case (op)
            OP_LOAD, OP_STORE: next_state = MEMADR;
            OP_R:              next_state = EXECR;
            OP_I:              next_state = EXECI;
            OP_BRANCH:         next_state = BEQ;
            OP_JAL:            next_state = JAL;
            default:           next_state = ILLEGAL;
          endcase
        end
      end
      MEMADR: begin
        ALUSrcA    = SRCA_A;
        ALUSrcB    = SRCB_IMM;
        next_state = (op == OP_STORE) ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        AdrSrc     = 1'b1;
        next_state = MEMWB;
      end
      MEMWB: begin
        ResultSrc  = RES_DATA;
        RegWrite   = 1'b1;
        next_state = FETCH;
      end
      MEMWRITE: begin
        AdrSrc     = 1'b1;
        MemWrite   = 1'b1;
        next_state = FETCH;
      end
      EXECR: begin
        ALUSrcA    = SRCA_A;
        ALUSrcB    = SRCB_B;
        alu_op     = ALUOP_FUNCT;
        next_state = ALUWB;
      end
      EXECI: begin
        ALUSrcA    = SRCA_A;
        ALUSrcB    = SRCB_IMM;
        alu_op     = ALUOP_FUNCT;
        next_state = ALUWB;
      end
      ALUWB: begin
        RegWrite   = 1'b1;
        next_state = FETCH;
      end
      BEQ: begin
        ALUSrcA    = SRCA_A;
        ALUSrcB    = SRCB_B;
        alu_op     = ALUOP_SUB;
        branch     = 1'b1;
        next_state = FETCH;
      end
      JAL: begin
        // OldPC + 4 becomes the link value; PC takes the target from ALUOut.
        ALUSrcA    = SRCA_OLDPC;
        ALUSrcB    = SRCB_FOUR;
        pc_update  = 1'b1;
        next_state = ALUWB;
      end
      ILLEGAL: begin
        illegal    = 1'b1;
        next_state = ILLEGAL;
      end
      default: next_state = ILLEGAL;
    endcase
  end

  assign PCWrite = pc_update | (branch & Zero);

  always_comb begin
    case (op)
      OP_STORE:  ImmSrc = IMM_S;
      OP_BRANCH: ImmSrc = IMM_B;
      OP_JAL:    ImmSrc = IMM_J;
      default:   ImmSrc = IMM_I;
    endcase
  end

  aludec u_aludec (
    .alu_op      (alu_op),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .op5         (op[5]),
    .alu_control (ALUControl),
    .unsupported (unsupported)
  );

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller. A reference model gives the expected
// control word for any instruction at a given cycle offset from FETCH.
module tb_multicycle_controller;

  typedef struct packed {
    logic       pcw;
    logic       adr;
    logic       memw;
    logic       irw;
    logic [1:0] res;
    logic [1:0] srca;
    logic [1:0] srcb;
    logic       regw;
    logic [1:0] imm;
    logic [2:0] aluc;
    logic       ill;
  } ctrl_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [6:0] op = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic       funct7b5 = 1'b0;
  logic       Zero = 1'b0;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;

  int total = 0;
  int bad   = 0;

  multicycle_controller dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .Zero       (Zero),
    .PCWrite    (PCWrite),
    .AdrSrc     (AdrSrc),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .ResultSrc  (ResultSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .RegWrite   (RegWrite),
    .ImmSrc     (ImmSrc),
    .ALUControl (ALUControl),
    .illegal    (illegal)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish (got=timeout need=finish)");
    $fatal(1);
  end

  // Instruction length in cycles; 0 means the encoding is rejected.
  function automatic int ilen(input logic [6:0] o, input logic [2:0] f3);
    case (o)
      7'b0000011:             return 5;
      7'b0100011:             return 4;
      7'b0110011, 7'b0010011: return (f3 == 3'd1 || f3 == 3'd3 || f3 == 3'd5) ? 0 : 4;
      7'b1100011:             return (f3 == 3'd0) ? 3 : 0;
      7'b1101111:             return 4;
      default:                return 0;
    endcase
  endfunction

  // Expected controls for instruction (o,f3,f7) at cycle cyc after FETCH.
  function automatic ctrl_t model(input logic [6:0] o, input logic [2:0] f3,
                                  input logic f7, input logic z, input int cyc);
    ctrl_t      c = '0;
    logic [2:0] code;
    case (o)
      7'b0100011: c.imm = 2'd1;
      7'b1100011: c.imm = 2'd2;
      7'b1101111: c.imm = 2'd3;
      default:    c.imm = 2'd0;
    endcase
    case (f3)
      3'd0:    code = (o[5] && f7) ? 3'd1 : 3'd0;
      3'd2:    code = 3'd5;
      3'd4:    code = 3'd4;
      3'd6:    code = 3'd3;
      3'd7:    code = 3'd2;
      default: code = 3'd0;
    endcase
    if (cyc == 0) begin
      c.irw = 1'b1; c.pcw = 1'b1; c.srcb = 2'd2; c.res = 2'd2;
    end else if (cyc == 1) begin
      c.srca = 2'd1; c.srcb = 2'd1;
    end else if (ilen(o, f3) == 0) begin
      c.ill = 1'b1;
    end else begin
      case (o)
        7'b0000011:
          if (cyc == 2)      begin c.srca = 2'd2; c.srcb = 2'd1; end
          else if (cyc == 3) c.adr = 1'b1;
          else               begin c.res = 2'd1; c.regw = 1'b1; end
        7'b0100011:
          if (cyc == 2) begin c.srca = 2'd2; c.srcb = 2'd1; end
          else          begin c.adr = 1'b1; c.memw = 1'b1; end
        7'b0110011:
          if (cyc == 2) begin c.srca = 2'd2; c.aluc = code; end
          else          c.regw = 1'b1;
        7'b0010011:
          if (cyc == 2) begin c.srca = 2'd2; c.srcb = 2'd1; c.aluc = code; end
          else          c.regw = 1'b1;
        7'b1100011: begin
          c.srca = 2'd2; c.aluc = 3'd1; c.pcw = z;
        end
        default:
          if (cyc == 2) begin c.srca = 2'd1; c.srcb = 2'd2; c.pcw = 1'b1; end
          else          c.regw = 1'b1;
      endcase
    end
    return c;
  endfunction

  function automatic ctrl_t dut_ctrl();
    ctrl_t c;
    c.pcw  = PCWrite;   c.adr  = AdrSrc;   c.memw = MemWrite; c.irw = IRWrite;
    c.res  = ResultSrc; c.srca = ALUSrcA;  c.srcb = ALUSrcB;  c.regw = RegWrite;
    c.imm  = ImmSrc;    c.aluc = ALUControl; c.ill = illegal;
    return c;
  endfunction

  task automatic test_reset();
    ctrl_t e, g;
    for (int i = 0; i < 2; i++) begin
      op = 7'($urandom); funct3 = 3'($urandom); Zero = 1'($urandom_range(0, 1));
      #1;
      e = model(op, funct3, funct7b5, Zero, 0); g = dut_ctrl();
      total++;
      if (g !== e) begin bad++; $display("FAIL reset_hold%0d got=%h exp=%h", i, g, e); end
      @(posedge clk); #1;
    end
    @(negedge clk); reset = 1'b1; #1;
    e = model(op, funct3, funct7b5, Zero, 0); g = dut_ctrl();
    total++;
    if (g !== e) begin bad++; $display("FAIL reset_release got=%h exp=%h", g, e); end
  endtask

  task automatic test_alu();
    logic [10:0] tbl [7] = '{{7'b0110011, 3'd4, 1'b0}, {7'b0110011, 3'd0, 1'b1},
                             {7'b0110011, 3'd6, 1'b0}, {7'b0010011, 3'd4, 1'b0},
                             {7'b0010011, 3'd0, 1'b1}, {7'b0010011, 3'd2, 1'b0},
                             {7'b0010011, 3'd7, 1'b1}};
    ctrl_t e, g;
    int    n;
    foreach (tbl[k]) begin
      {op, funct3, funct7b5} = tbl[k];
      n = ilen(op, funct3);
      for (int i = 0; i <= n; i++) begin
        Zero = 1'($urandom_range(0, 1)); #1;
        e = model(op, funct3, funct7b5, Zero, i % n); g = dut_ctrl();
        total++;
        if (g !== e) begin bad++; $display("FAIL alu%0d cyc%0d got=%h exp=%h", k, i, g, e); end
        if (i < n) begin @(posedge clk); #1; end
      end
    end
  endtask

  task automatic test_mem();
    logic [6:0] ops [2] = '{7'b0100011, 7'b0000011};
    ctrl_t e, g;
    int    n;
    foreach (ops[k]) begin
      op = ops[k]; funct3 = 3'd2; funct7b5 = 1'($urandom);
      n = ilen(op, funct3);
      for (int i = 0; i <= n; i++) begin
        Zero = 1'($urandom_range(0, 1)); #1;
        e = model(op, funct3, funct7b5, Zero, i % n); g = dut_ctrl();
        total++;
        if (g !== e) begin bad++; $display("FAIL mem%0d cyc%0d got=%h exp=%h", k, i, g, e); end
        if (i < n) begin @(posedge clk); #1; end
      end
    end
  endtask

  task automatic test_beq();
    ctrl_t e, g;
    op = 7'b1100011; funct3 = 3'd0; funct7b5 = 1'b0;
    for (int z = 1; z >= 0; z--) begin
      Zero = 1'(z);
      for (int i = 0; i <= 3; i++) begin
        #1;
        e = model(op, funct3, funct7b5, Zero, i % 3); g = dut_ctrl();
        total++;
        if (g !== e) begin bad++; $display("FAIL beq_z%0d cyc%0d got=%h exp=%h", z, i, g, e); end
        if (i < 3) begin @(posedge clk); #1; end
      end
    end
  endtask

  task automatic test_illegal();
    ctrl_t e, g;
    op = 7'b1111111; funct3 = 3'($urandom); funct7b5 = 1'($urandom);
    for (int i = 0; i < 12; i++) begin
      Zero = 1'($urandom_range(0, 1)); #1;
      e = model(op, funct3, funct7b5, Zero, i); g = dut_ctrl();
      total++;
      if (g !== e) begin bad++; $display("FAIL illegal cyc%0d got=%h exp=%h", i, g, e); end
      @(posedge clk); #1;
    end
    #1 reset = 1'b0; #1;
    e = model(op, funct3, funct7b5, Zero, 0); g = dut_ctrl();
    total++;
    if (g !== e) begin bad++; $display("FAIL illegal_reset got=%h exp=%h", g, e); end
    @(negedge clk); reset = 1'b1; #1;
    g = dut_ctrl();
    total++;
    if (g !== e) begin bad++; $display("FAIL illegal_release got=%h exp=%h", g, e); end
  endtask

  task automatic test_reset_mid();
    ctrl_t e, g;
    op = 7'b0100011; funct3 = 3'd2; funct7b5 = 1'b0;
    for (int i = 0; i <= 3; i++) begin
      Zero = 1'($urandom_range(0, 1)); #1;
      e = model(op, funct3, funct7b5, Zero, i); g = dut_ctrl();
      total++;
      if (g !== e) begin bad++; $display("FAIL midrst_pre cyc%0d got=%h exp=%h", i, g, e); end
      if (i < 3) begin @(posedge clk); #1; end
    end
    // In MEMWRITE now: pulling reset must drop MemWrite at once.
    #1 reset = 1'b0; #1;
    e = model(op, funct3, funct7b5, Zero, 0); g = dut_ctrl();
    total++;
    if (g !== e) begin bad++; $display("FAIL midrst_assert got=%h exp=%h", g, e); end
    @(posedge clk); #1;
    g = dut_ctrl();
    total++;
    if (g !== e) begin bad++; $display("FAIL midrst_hold got=%h exp=%h", g, e); end
    @(negedge clk); reset = 1'b1;
    for (int i = 0; i <= 4; i++) begin
      Zero = 1'($urandom_range(0, 1)); #1;
      e = model(op, funct3, funct7b5, Zero, i % 4); g = dut_ctrl();
      total++;
      if (g !== e) begin bad++; $display("FAIL midrst_post cyc%0d got=%h exp=%h", i, g, e); end
      if (i < 4) begin @(posedge clk); #1; end
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0] ops [6] = '{7'b0000011, 7'b0100011, 7'b0110011,
                            7'b0010011, 7'b1100011, 7'b1101111};
    ctrl_t e, g;
    int    n, lim, sel;
    for (int k = 0; k < 40; k++) begin
      sel = $urandom_range(0, 6);
      op = (sel == 6) ? 7'($urandom) : ops[sel];
      funct3 = 3'($urandom); funct7b5 = 1'($urandom);
      n = ilen(op, funct3);
      lim = (n == 0) ? 4 : n;
      for (int i = 0; i <= lim; i++) begin
        Zero = 1'($urandom_range(0, 1)); #1;
        e = model(op, funct3, funct7b5, Zero, (n == 0) ? i : i % n); g = dut_ctrl();
        total++;
        if (g !== e) begin
          bad++;
          $display("FAIL rand%0d op=%b f3=%0d cyc%0d got=%h exp=%h", k, op, funct3, i, g, e);
        end
        if (i < lim) begin @(posedge clk); #1; end
      end
      if (n == 0) begin
        reset = 1'b0; #1;
        e = model(op, funct3, funct7b5, Zero, 0); g = dut_ctrl();
        total++;
        if (g !== e) begin bad++; $display("FAIL rand%0d recover got=%h exp=%h", k, g, e); end
        @(negedge clk); reset = 1'b1; #1;
      end
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_mem();
    test_beq();
    test_reset_mid();
    test_illegal();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Control unit for the multicycle RV32I datapath (shared instruction/data memory, IR, OldPC, A/B, ALUOut and Data registers).
- A Moore main FSM sequences each instruction over 3–5 cycles; a combinational ALU decoder and an immediate decoder complete the block.
- Supported instructions: lw, sw, R-type add/sub/and/or/xor/slt, I-type addi/andi/ori/xori/slti, beq, jal.
- Any unsupported encoding parks the FSM in a sticky ILLEGAL state.

Parameters:
- RESET_STATE, FETCH, state entered on reset (kept as a parameter so benches can check it; not overridden in synthesis).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset; one clock
- op  in  7  Instr[6:0] from IR
- funct3  in  3  Instr[14:12]
- funct7b5  in  1  Instr[30]
- Zero  in  1  ALU zero flag
- PCWrite  out  1  PC register enable
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut
- MemWrite  out  1  memory write enable
- IRWrite  out  1  IR and OldPC enable
- ResultSrc  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult
- ALUSrcA  out  2  00 = PC, 01 = OldPC, 10 = A
- ALUSrcB  out  2  00 = B, 01 = ImmExt, 10 = constant 4
- RegWrite  out  1  register file write enable
- ImmSrc  out  2  00 = I, 01 = S, 10 = B, 11 = J
- ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt
- illegal  out  1  high while in ILLEGAL

Behaviour:
- State register
  - Updated on posedge clk. reset low clears it asynchronously to FETCH.
  - During reset all outputs take their FETCH values.
- Fetch outputs: IRWrite = 1, AdrSrc = 0, ALUSrcA = 00, ALUSrcB = 10, ALUOp = 00, ResultSrc = 10, PCUpdate = 1.
- Write-enable rule: every write enable not listed for a state is 0.
  - PCWrite = PCUpdate | (Branch & Zero), evaluated combinationally in the same cycle.
- States, asserted controls, and next state:
  - FETCH: as above -> DECODE.
  - DECODE: ALUSrcA = 01, ALUSrcB = 01, ALUOp = 00 (branch target into ALUOut). Next state by op:
    - 0000011 or 0100011 -> MEMADR
    - 0110011 -> EXECR
    - 0010011 -> EXECI
    - 1100011 -> BEQ
    - 1101111 -> JAL
    - anything else -> ILLEGAL
    - DECODE also goes to ILLEGAL when the ALU decoder flags an unsupported funct3 for op 0110011/0010011, or when funct3 != 000 for beq.
  - MEMADR: ALUSrcA = 10, ALUSrcB = 01, ALUOp = 00 -> MEMREAD (lw) or MEMWRITE (sw).
  - MEMREAD: AdrSrc = 1, ResultSrc = 00 -> MEMWB.
  - MEMWB: ResultSrc = 01, RegWrite = 1 -> FETCH.
  - MEMWRITE: AdrSrc = 1, ResultSrc = 00, MemWrite = 1 -> FETCH.
  - EXECR: ALUSrcA = 10, ALUSrcB = 00, ALUOp = 10 -> ALUWB.
  - EXECI: ALUSrcA = 10, ALUSrcB = 01, ALUOp = 10 -> ALUWB.
  - ALUWB: ResultSrc = 00, RegWrite = 1 -> FETCH.
  - BEQ: ALUSrcA = 10, ALUSrcB = 00, ALUOp = 01, ResultSrc = 00, Branch = 1 -> FETCH.
  - JAL: ALUSrcA = 01, ALUSrcB = 10, ALUOp = 00, ResultSrc = 00, PCUpdate = 1 -> ALUWB.
  - ILLEGAL: all write enables 0, illegal = 1. Holds until reset.
- ALU decoder (combinational)
  - ALUOp 00 -> add; 01 -> sub.
  - ALUOp 10, by funct3:
    - 000 -> sub when op[5] & funct7b5, else add
    - 010 -> slt
    - 100 -> xor
    - 110 -> or
    - 111 -> and
    - any other funct3 -> add, and the unsupported flag is raised.
  - xori/xor use the same code (100). Immediates are sign-extended by the datapath from ImmSrc = 00.
- ImmSrc is decoded from op in every state: lw/I-type 00, sw 01, beq 10, jal 11, other 00.
- Cycle counts: lw 5; sw, R, I, jal 4; beq 3.
- Reset asserted mid-instruction: outputs drop to FETCH values immediately and no write enable glitches high. The next instruction starts at the first posedge after release.

Decomposition:
- Shared package riscv_ctrl_pkg holds:
  - state enum statetype
  - ALUControl, ResultSrc, ALUSrcA/B and ImmSrc localparams
  - opcode constants OP_LOAD, OP_STORE, OP_R, OP_I, OP_BRANCH, OP_JAL
- One natural sub-module: aludec (ALUOp, funct3, funct7b5, op5 -> ALUControl, unsupported). The FSM and immediate decode stay in the top block.

Test Plan:
- Hold reset low for 2 cycles, then release -> state FETCH; IRWrite = 1, PCWrite = 1, ALUSrcB = 10, MemWrite = 0, RegWrite = 0.
- Present xor (op 0110011, funct3 100, funct7b5 0) -> states FETCH, DECODE, EXECR, ALUWB, FETCH; ALUControl = 100 in EXECR; RegWrite = 1 only in cycle 4; MemWrite = 0 throughout.
- Present xori (op 0010011, funct3 100) -> EXECI shows ALUSrcB = 01, ALUControl = 100, ImmSrc = 00. Repeat with funct3 000 and funct7b5 = 1 (addi) -> ALUControl = 000, not sub.
- Present sw, then lw -> sw gives MemWrite = 1 for exactly one cycle with AdrSrc = 1, 4 cycles total. lw gives RegWrite with ResultSrc = 01 in cycle 5.
- Present beq with Zero = 1, then again with Zero = 0 -> PCWrite = 1 in BEQ only when Zero = 1; 3 cycles each; ImmSrc = 10.
- Present op 1111111 -> ILLEGAL after DECODE; illegal = 1 and all enables 0 for 10 cycles. Assert reset low mid-stay -> FETCH, illegal = 0.
